// File: rtl/stream_reducer.sv
// Stream sink that drains one generator output stream and reduces it to
// sum / count / min / max, presented as a single ready/valid result tuple.
module stream_reducer #(
  parameter int WIDTH       = 32,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                          _clock,
  input  logic                          _reset,
  input  logic                          _start,
  output logic                          in_start,
  output logic                          in_ready,
  input  logic                          in_valid,
  input  logic                          in_done,
  input  logic signed [WIDTH-1:0]       in_data,
  input  logic                          _ready,
  output logic                          _valid,
  output logic                          _done,
  output logic signed [WIDTH-1:0]       _out0,
  output logic        [COUNT_WIDTH-1:0] _out1,
  output logic signed [WIDTH-1:0]       _out2,
  output logic signed [WIDTH-1:0]       _out3
);

  typedef enum logic [2:0] {
    DONE,
    LAUNCH,
    GUARD,
    COLLECT,
    RESULT
  } state_t;

  localparam logic signed [WIDTH-1:0] MIN_INIT = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MAX_INIT = {1'b1, {(WIDTH-1){1'b0}}};

  state_t                   state, state_n;
  logic signed [WIDTH-1:0]  sum, sum_n;
  logic signed [WIDTH-1:0]  min_v, min_n;
  logic signed [WIDTH-1:0]  max_v, max_n;
  logic [COUNT_WIDTH-1:0]   count, count_n;
  logic                     accept;
  logic                     valid_n, done_n, in_start_n, in_ready_n;
  logic signed [WIDTH-1:0]  out0_n, out2_n, out3_n;
  logic [COUNT_WIDTH-1:0]   out1_n;

  always_ff @(posedge _clock or posedge _reset) begin
    if (_reset) begin
      state    <= DONE;
      sum      <= '0;
      min_v    <= '0;
      max_v    <= '0;
      count    <= '0;
      _valid   <= 1'b0;
      _done    <= 1'b1;
      in_start <= 1'b0;
      in_ready <= 1'b0;
      _out0    <= '0;
      _out1    <= '0;
      _out2    <= '0;
      _out3    <= '0;
    end else begin
      state    <= state_n;
      sum      <= sum_n;
      min_v    <= min_n;
      max_v    <= max_n;
      count    <= count_n;
      _valid   <= valid_n;
      _done    <= done_n;
      in_start <= in_start_n;
      in_ready <= in_ready_n;
      _out0    <= out0_n;
      _out1    <= out1_n;
      _out2    <= out2_n;
      _out3    <= out3_n;
    end
  end

  always_comb begin
    state_n    = state;
    sum_n      = sum;
    min_n      = min_v;
    max_n      = max_v;
    count_n    = count;
    valid_n    = _valid;
    done_n     = _done;
    in_start_n = 1'b0;
    in_ready_n = in_ready;
    out0_n     = _out0;
    out1_n     = _out1;
    out2_n     = _out2;
    out3_n     = _out3;
    // in_ready is only high in GUARD/COLLECT, so this alone gates acceptance
    accept     = in_valid && in_ready;

    if (_start) begin
      state_n    = LAUNCH;
      sum_n      = '0;
      count_n    = '0;
      min_n      = MIN_INIT;
      max_n      = MAX_INIT;
      valid_n    = 1'b0;
      done_n     = 1'b0;
      in_ready_n = 1'b0;
      in_start_n = 1'b1;
    end else begin
      if (accept) begin
        sum_n = sum + in_data;
        if (count != '1) begin
          count_n = count + 1'b1;
        end
        if (in_data < min_v) begin
          min_n = in_data;
        end
        if (in_data > max_v) begin
          max_n = in_data;
        end
      end

      case (state)
        DONE: begin
          done_n     = 1'b1;
          in_ready_n = 1'b0;
        end
        LAUNCH: begin
          in_ready_n = 1'b1;
          state_n    = GUARD;
        end
        // upstream _done may still be asserted from its previous run here
        GUARD: begin
          state_n = COLLECT;
        end
        COLLECT: begin
          if (in_done && !in_valid) begin
            in_ready_n = 1'b0;
            valid_n    = 1'b1;
            state_n    = RESULT;
            if (count == '0) begin
              out0_n = '0;
              out1_n = '0;
              out2_n = '0;
              out3_n = '0;
            end else begin
              out0_n = sum;
              out1_n = count;
              out2_n = min_v;
              out3_n = max_v;
            end
          end
        end
        RESULT: begin
          if (_ready) begin
            valid_n = 1'b0;
            done_n  = 1'b1;
            state_n = DONE;
          end
        end
        default: begin
          state_n = DONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stream_reducer.sv
// Bench for stream_reducer: behavioural upstream producer, scoreboard of
// expected result tuples popped at each downstream handshake.
module tb_stream_reducer;
  localparam int W  = 8;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst, start, in_start, in_ready, in_valid, in_done, rdy, valid, done;
  logic signed [W-1:0] in_data, out0, out2, out3;
  logic [CW-1:0] out1;

  always #5 clk = ~clk;

  stream_reducer #(.WIDTH(W), .COUNT_WIDTH(CW)) dut (
    ._clock  (clk),
    ._reset  (rst),
    ._start  (start),
    .in_start(in_start),
    .in_ready(in_ready),
    .in_valid(in_valid),
    .in_done (in_done),
    .in_data (in_data),
    ._ready  (rdy),
    ._valid  (valid),
    ._done   (done),
    ._out0   (out0),
    ._out1   (out1),
    ._out2   (out2),
    ._out3   (out3)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  typedef struct {
    int sum;
    int cnt;
    int mn;
    int mx;
  } res_t;
  res_t sb[$];

  // upstream producer model
  int run_items[$];
  int run_stale;
  bit run_dwl;
  int items[$];
  int stale;
  bit dwl;
  bit active = 1'b0;
  bit fire = 1'b0;
  bit idle_valid;
  int pulses = 0;

  initial begin
    in_valid = 1'b0;
    in_done  = 1'b1;
    in_data  = '0;
    forever begin
      @(posedge clk); #1;
      if (in_start) begin
        items  = run_items;
        stale  = run_stale;
        dwl    = run_dwl;
        active = 1'b1;
      end else if (active) begin
        if (fire && items.size() > 0) items.delete(0);
        if (stale > 0) stale--;
      end
      if (active) begin
        in_valid = (items.size() > 0) && (stale == 0);
        in_data  = (items.size() > 0) ? W'(items[0]) : '0;
        in_done  = (stale > 0) || (items.size() == 0) || (dwl && items.size() == 1);
      end else begin
        in_valid = idle_valid;
        in_data  = 8'sd55;
        in_done  = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    fire = in_valid && in_ready;
    if (in_start) pulses++;
  end

  always @(negedge clk) begin : monitor
    res_t e;
    if (!rst) begin
      if (valid) check("done_low_while_valid", done, 0);
      if (valid && rdy) begin
        if (sb.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          e = sb.pop_front();
          check("out0_sum", out0, e.sum);
          check("out1_count", out1, e.cnt);
          check("out2_min", out2, e.mn);
          check("out3_max", out3, e.mx);
        end
      end
    end
  end

  task automatic start_run(input int it[$], input int st, input bit d, input bit push,
                           input int es, input int ec, input int emn, input int emx);
    res_t r;
    run_items = it;
    run_stale = st;
    run_dwl   = d;
    if (push) begin
      r.sum = es; r.cnt = ec; r.mn = emn; r.mx = emx;
      sb.push_back(r);
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!valid && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_valid_seen"}, valid, 1);
  endtask

  task automatic wait_result(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_result_consumed"}, sb.size(), 0);
    sb.delete();
    check({tag, "_done_after"}, done, 1);
    check({tag, "_valid_after"}, valid, 0);
  endtask

  initial begin
    int q[$];
    rst        = 1'b1;
    start      = 1'b0;
    rdy        = 1'b1;
    idle_valid = 1'b0;
    run_stale  = 0;
    run_dwl    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", valid, 0);
    check("rst_done", done, 1);
    check("rst_in_start", in_start, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out0", out0, 0);
    check("rst_out1", out1, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // items offered while idle are not consumed
    idle_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_in_ready", in_ready, 0);
    check("idle_done", done, 1);
    idle_valid = 1'b0;

    q = {1, 4, 7, 10};
    start_run(q, 0, 1'b0, 1'b1, 22, 4, 1, 10);
    check("launch_in_start", in_start, 1);
    check("launch_done_low", done, 0);
    wait_result("hrange");

    start_run(q, 2, 1'b0, 1'b1, 22, 4, 1, 10);
    wait_result("stale_guard");

    q.delete();
    start_run(q, 2, 1'b0, 1'b1, 0, 0, 0, 0);
    wait_result("empty");

    rdy = 1'b0;
    q = {-5, 20, 3};
    start_run(q, 0, 1'b0, 1'b1, 18, 3, -5, 20);
    wait_valid("bp");
    repeat (5) begin
      @(posedge clk); #1;
      check("bp_hold_valid", valid, 1);
      check("bp_hold_out0", out0, 18);
      check("bp_hold_out1", out1, 3);
      check("bp_hold_out2", out2, -5);
      check("bp_hold_out3", out3, 20);
    end
    rdy = 1'b1;
    wait_result("bp");

    q = {100, 100, -3};
    start_run(q, 0, 1'b1, 1'b1, -59, 3, -3, 100);
    wait_result("wrap");

    q = {-128, 127, 1, 1, 1, 1, 1, 1, 1, 1};
    start_run(q, 0, 1'b0, 1'b1, 7, 7, -128, 127);
    wait_result("saturate");

    q = {1, 2, 3, 4, 5, 6, 7, 8};
    start_run(q, 2, 1'b0, 1'b0, 0, 0, 0, 0);
    repeat (4) @(posedge clk);
    #1;
    check("pre_reset_in_ready", in_ready, 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_in_ready", in_ready, 0);
    check("async_rst_valid", valid, 0);
    check("async_rst_done", done, 1);
    rst = 1'b0;
    @(posedge clk); #1;
    q = {1, 4, 7, 10};
    start_run(q, 0, 1'b0, 1'b1, 22, 4, 1, 10);
    wait_result("after_reset");

    rdy = 1'b0;
    q = {5, 6};
    start_run(q, 0, 1'b0, 1'b0, 0, 0, 0, 0);
    wait_valid("abort_first");
    pulses = 0;
    q = {2, 3, -1};
    start_run(q, 0, 1'b0, 1'b1, 4, 3, -1, 3);
    check("abort_valid_dropped", valid, 0);
    rdy = 1'b1;
    wait_result("abort_second");
    check("abort_in_start_pulses", pulses, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stream_reducer.md
Name: stream_reducer

Overview:
Downstream consumer for any generated generator module with a single-output stream (`_out0`). It drives the producer's `_start` and `_ready` and drains the stream through the ready/valid handshake. It reduces the stream to sum, count, min and max, then presents the result as one ready/valid output tuple followed by `_done`. It closes a generator pipeline, for example hrange → stream_reducer, without a testbench sink.

Parameters:
WIDTH, 32, width of the signed data items, sum, min and max
COUNT_WIDTH, 16, width of the unsigned item counter

Ports:
_clock  input  1  clock; all state updates on the rising edge
_reset  input  1  asynchronous active-high reset
_start  input  1  synchronous; clears accumulators and launches the upstream producer
in_start  output  1  drives the upstream `_start`; one-cycle pulse
in_ready  output  1  drives the upstream `_ready`
in_valid  input  1  upstream `_valid`
in_done  input  1  upstream `_done`
in_data  input  WIDTH  upstream `_out0`, signed
_ready  input  1  downstream ready for the result
_valid  output  1  result tuple valid
_done  output  1  high while idle or finished
_out0  output  WIDTH  signed sum of the items
_out1  output  COUNT_WIDTH  number of items accepted
_out2  output  WIDTH  signed minimum of the items
_out3  output  WIDTH  signed maximum of the items

Behaviour:
- States: DONE, LAUNCH, GUARD, COLLECT, RESULT.
- All outputs are registered.
- Reset (async, any state):
  - state goes to DONE
  - `_valid`, `in_start`, `in_ready`, `_out0`..`_out3` all 0
  - `_done` is 1
- `_start` is sampled every cycle, in any state, and takes precedence over all other activity. On the next edge:
  - sum = 0, count = 0, min = +max(WIDTH), max = -min(WIDTH)
  - `_valid` = 0, `_done` = 0, `in_ready` = 0, `in_start` = 1
  - state goes to LAUNCH
- A `_start` while in COLLECT or RESULT aborts the run: the pending result is dropped and the run relaunches.
- LAUNCH:
  - `in_start` drops to 0 and `in_ready` rises to 1
  - state goes to GUARD
- GUARD (exactly one cycle):
  - `in_done` is ignored, because the upstream `_done` from its previous run is stale here
  - items are accepted if `in_valid` && `in_ready`
  - state goes to COLLECT
- Item acceptance, in GUARD or COLLECT, whenever `in_valid` && `in_ready` at an edge:
  - sum += `in_data`, wrapping modulo 2^WIDTH with no saturation
  - count += 1, saturating at 2^COUNT_WIDTH-1
  - min/max updated with signed comparison
- COLLECT end of stream:
  - End of stream is recognised when `in_done` = 1 and `in_valid` = 0 at an edge.
  - If `in_done` and `in_valid` are both 1, the item is accepted and termination is re-evaluated on the next cycle (upstream holds `_done`).
  - On recognition: `in_ready` goes to 0 and state goes to RESULT.
  - Outputs load on the same edge: `_out0` = sum, `_out1` = count, `_out2` = min, `_out3` = max, `_valid` = 1.
  - Latency from the last accepted item to `_valid` is at least 1 cycle and depends on when upstream raises `_done`.
- Empty stream (count = 0):
  - `_out0`, `_out2`, `_out3` are reported as 0 and `_out1` as 0
  - the min/max sentinels are never exposed
- RESULT:
  - outputs are held stable while `_valid` = 1 and `_ready` = 0
  - on an edge with `_ready` = 1, `_valid` goes to 0, `_done` goes to 1 and state goes to DONE
  - `_valid` and `_done` are never high together
- DONE:
  - `_done` stays 1
  - `in_ready` = 0 and `in_start` = 0
  - upstream `in_valid`/`in_data` are ignored
- `in_ready` is only ever 1 in GUARD and COLLECT, so items presented outside a run are never consumed.

Test Plan:
- Upstream hrange(1,11,3) with `_ready` held 1 → items 1,4,7,10 accepted → `_out0`=22, `_out1`=4, `_out2`=1, `_out3`=10, `_valid` for 1 cycle, then `_done`=1.
- Empty stream hrange(5,5,1), with stale upstream `in_done`=1 during LAUNCH/GUARD → no early exit; result 0/0/0/0, `_valid`=1, then `_done`.
- Downstream backpressure: `_ready`=0 for 5 cycles in RESULT → `_out0`..`_out3` and `_valid`=1 unchanged; the cycle after `_ready`=1 gives `_valid`=0, `_done`=1.
- Wrap: WIDTH=8, items 100,100,-3 → `_out0`=-59 (197 wraps to -59), `_out1`=3, `_out2`=-3, `_out3`=100; `in_done`+`in_valid` on the last item → item counted.
- Reset asserted asynchronously mid-COLLECT (between edges) → `in_ready`/`_valid` go to 0 immediately and `_done`=1; a subsequent `_start` gives a correct fresh run (sum 22 on the first stimulus).
- `_start` re-asserted in RESULT with `_ready`=0 → old result dropped, `in_start` pulses once, new run completes with correct values.
